// File: rtl/serializer_pkg.sv
// Shared types and build-time constants for the serial operand serializer.
// SERIALIZER_EXTRA_BIT_EN appends one zero bit per word so the adder can emit its carry-out.
package serializer_pkg;

    typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

`ifdef SERIALIZER_EXTRA_BIT_EN
    localparam int EXTRA_BITS = 1;
`else
    localparam int EXTRA_BITS = 0;
`endif

endpackage

// File: rtl/serial_operand_serializer_piso.sv
// Parallel-in serial-out shift register; loads a word and shifts it right, LSB appearing on o_q.
// Zeros are shifted in from the top, so o_q reads 0 once the word has fully drained.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_q
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_d;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_q = r_data[0];

endmodule

// File: rtl/serial_operand_serializer.sv
// Serializes operand pairs LSB-first with first/last framing for the 1-bit serial adder.
// Build option SERIALIZER_EXTRA_BIT_EN stretches each word by one trailing zero bit.
module serial_operand_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1 + EXTRA_BITS);

    ser_state_t       r_state;
    ser_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_bit_valid;
    logic             r_first;
    logic             r_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_shift;
    logic             w_bv_next;
    logic             w_first_next;
    logic             w_last_next;

    // A new word may enter in the final bit cycle, which is what removes the bubble.
    assign w_ready  = (r_state == S_IDLE) | ((r_state == S_SHIFT) & r_last);
    assign w_accept = in_valid & w_ready;
    assign w_shift  = (r_state == S_SHIFT) & ~w_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_SHIFT;
                    w_cnt_next   = '0;
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    w_cnt_next = '0;
                end else if (r_last) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_bv_next    = (w_next_state == S_SHIFT);
        w_first_next = w_accept;
        w_last_next  = w_bv_next & (w_cnt_next == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_bit_valid <= w_bv_next;
            r_first     <= w_first_next;
            r_last      <= w_last_next;
        end
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_d     (in_a),
        .o_q     (a)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_d     (in_b),
        .o_q     (b)
    );

    assign in_ready  = w_ready;
    assign bit_valid = r_bit_valid;
    assign first     = r_first;
    assign last      = r_last;
    assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Scoreboard bench for serial_operand_serializer; word length follows SERIALIZER_EXTRA_BIT_EN.
module tb_serial_operand_serializer;

`ifdef SERIALIZER_EXTRA_BIT_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       serA;
    logic       serB;
    logic       bitValid;
    logic       firstBit;
    logic       lastBit;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         runLen = 0;
    int         maxRun = 0;
    logic [3:0] sbQ[$];

    serial_operand_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_a      (inA),
        .in_b      (inB),
        .a         (serA),
        .b         (serB),
        .bit_valid (bitValid),
        .first     (firstBit),
        .last      (lastBit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offers one pair and waits for the handshake; the expected bit stream is queued on acceptance.
    // in_valid is left high so back-to-back callers can chain words without a gap.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb);
        bit accepted = 0;
        bit rdy;
        inA     = va;
        inB     = vb;
        inValid = 1'b1;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            rdy = inReady;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            for (int k = 0; k < NB; k++) begin
                logic ea;
                logic eb;
                ea = (k < 8) ? va[k] : 1'b0;
                eb = (k < 8) ? vb[k] : 1'b0;
                sbQ.push_back({ea, eb, k == 0, k == NB - 1});
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every live bit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bitValid) begin
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_bit", 1, 0);
            end else begin
                logic [3:0] exp;
                exp = sbQ.pop_front();
                checkOutput("bit_abfl", {28'd0, serA, serB, firstBit, lastBit}, {28'd0, exp});
            end
        end else begin
            runLen = 0;
        end
    end

    initial begin
        int idleBad;
        rst     = 1'b1;
        inValid = 1'b0;
        inA     = 8'h00;
        inB     = 8'h00;
        #1 rst  = 1'b0;
        #2;
        checkOutput("rst_a", serA, 0);
        checkOutput("rst_b", serB, 0);
        checkOutput("rst_bit_valid", bitValid, 0);
        checkOutput("rst_first", firstBit, 0);
        checkOutput("rst_last", lastBit, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", inReady, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        waitCycles(1);

        $display("[TB] idle hold");
        idleBad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bitValid || firstBit || lastBit || !inReady || busy) idleBad++;
        end
        checkOutput("idle_hold", idleBad, 0);
        waitCycles(1);

        $display("[TB] single word 5A/3C");
        applyStimulus(8'h5A, 8'h3C);
        inValid = 1'b0;
        waitCycles(NB + 2);
        checkOutput("single_done_bv", bitValid, 0);
        checkOutput("single_done_ready", inReady, 1);
        checkOutput("single_drained", sbQ.size(), 0);

        $display("[TB] back-to-back FF/01 then 00/80");
        maxRun = 0;
        applyStimulus(8'hFF, 8'h01);
        applyStimulus(8'h00, 8'h80);
        inValid = 1'b0;
        waitCycles(NB + 3);
        checkOutput("b2b_run_length", maxRun, 2 * NB);
        checkOutput("b2b_drained", sbQ.size(), 0);

        $display("[TB] blocked handshake");
        applyStimulus(8'hC3, 8'h96);
        inValid = 1'b0;
        waitCycles(2);
        inValid = 1'b1;
        inA     = 8'h11;
        inB     = 8'h22;
        #1;
        checkOutput("blocked_ready", inReady, 0);
        checkOutput("blocked_busy", busy, 1);
        waitCycles(1);
        applyStimulus(8'h7E, 8'h81);
        inValid = 1'b0;
        waitCycles(NB + 3);
        checkOutput("blocked_drained", sbQ.size(), 0);

        $display("[TB] reset mid-word");
        applyStimulus(8'hAA, 8'h55);
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_a", serA, 0);
        checkOutput("midrst_b", serB, 0);
        checkOutput("midrst_bit_valid", bitValid, 0);
        checkOutput("midrst_first", firstBit, 0);
        checkOutput("midrst_last", lastBit, 0);
        checkOutput("midrst_busy", busy, 0);
        sbQ.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        waitCycles(1);
        applyStimulus(8'h01, 8'h01);
        inValid = 1'b0;
        waitCycles(NB + 2);
        checkOutput("postrst_drained", sbQ.size(), 0);
        checkOutput("postrst_ready", inReady, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
